hsv_decoder_pipe: RTL and testbench
===================================

# hsv_decoder_pipe

Parametrised, back-pressurable successor to the HSV front-end decoder. It accepts RGB565 or RGB888 pixels under a per-pixel format select and expands each channel to `COMP_W` bits. For each pixel it produces the HSV Value, the signed hue dividend, the max−min delta and the max-channel function code, plus an achromatic flag. It sits between the pixel source and the hue/saturation divider stages, with a 2-stage valid/ready pipeline.

## Interface
- `COMP_W`, default 8: component width after expansion; legal range 8..12.
- `i_clk`  in  1  sole clock; all logic on the rising edge.
- `i_rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `i_data`  in  24  pixel.
  - RGB888: R=[23:16], G=[15:8], B=[7:0].
  - RGB565: R=[15:11], G=[10:5], B=[4:0]; bits [23:16] ignored.
- `i_fmt`  in  1  0 = RGB565, 1 = RGB888; qualified by `i_valid`.
- `i_valid`  in  1  input pixel valid.
- `o_ready`  out  1  block can accept a pixel this cycle.
- `o_value`  out  COMP_W  unsigned max(R,G,B).
- `o_dividend`  out  COMP_W+1  two's-complement hue dividend.
- `o_delta`  out  COMP_W+1  max−min, MSB always 0.
- `o_function`  out  2  1 = R max, 2 = G max, 3 = B max.
- `o_gray`  out  1  delta == 0 (achromatic).
- `o_valid`  out  1  output beat valid.
- `i_ready`  in  1  downstream accepts the beat.
- Stats ports, present only with `HSV_DEC_STATS_EN`:
  - `i_clr_stats`  in  1  synchronous counter clear.
  - `o_pix_cnt`  out  32  count of output handshakes.
  - `o_gray_cnt`  out  32  count of output handshakes with `o_gray` = 1.

## Operation
- **Expansion:** each channel is left-justified into COMP_W bits with zero LSB padding.
  - RGB565 at COMP_W=8: R,B <<3; G <<2.
  - RGB888 at COMP_W>8: <<(COMP_W−8).
- **Stage 1 (S1):** register the expanded R,G,B and the comparison results.
- **Stage 2 (S2):** compute outputs.
- **Max selection (ties):** R if R≥G and R≥B; else G if G≥B; else B.
- **Outputs:**
  - R max: function 1, dividend G−B, delta R−min(G,B).
  - G max: function 2, dividend B−R, delta G−min(R,B).
  - B max: function 3, dividend R−G, delta B−min(R,G).
- **Arithmetic:** all differences are computed at COMP_W+1 bits signed. No overflow is possible.
- `o_gray` = (delta == 0).
- **Handshake:** standard valid/ready at both ports.
  - Input transfer occurs when `i_valid` & `o_ready`.
  - Output transfer occurs when `o_valid` & `i_ready`.
- **Stage advance:** each stage holds one beat. A stage loads when it is empty or when its content moves on in the same cycle.
  - `o_ready` = !S1_full | (S1 advancing into S2).
  - S2 advances when !`o_valid` | `i_ready`.
- **Stall rule:** while `o_valid` & !`i_ready`, all outputs are held stable. No beat is dropped or duplicated.
- **Idle outputs:** when `o_valid` = 0, data outputs hold their last values.
- `i_fmt` travels with its pixel. Mixing formats on consecutive beats is legal.

## Timing
- **Reset:** all outputs and internal registers are 0 (`o_valid` = 0, `o_function` = 0); stats counters are 0. `o_ready` is 1 while idle, including during reset.
- **Reset mid-stream:** in-flight beats are discarded immediately. The first valid output appears 2 cycles after the first post-reset input transfer.
- **Latency:** 2 cycles from input transfer to `o_valid` when `i_ready` is held high.
- **Throughput:** 1 pixel/cycle.
- **Buffering:** with `i_ready` low, at most 2 beats are accepted. `o_ready` falls on the cycle after S1 fills behind a stalled S2.
- **Resuming:** raising `i_ready` after a stall reasserts `o_ready` the same cycle, because the ready path is combinational through both stages.
- **Stats counters:**
  - Update on the output-handshake edge.
  - Wrap from 2^32−1 to 0.
  - `i_clr_stats` coincident with a handshake leaves the counter at 0 (clear wins).

## Configuration
- `HSV_DEC_STATS_EN` defined: stats ports and both 32-bit counters are compiled in.
- `HSV_DEC_STATS_EN` undefined: stats ports and counters are absent. The datapath is identical in function and timing.

## Test plan
- **RGB565 primaries:** `i_fmt`=0, `i_data`=0x00F800, COMP_W=8 → value 248, function 1, dividend 0, delta 248, gray 0. Then 0x0007E0 → value 252, function 2, delta 252.
- **RGB888 blue and tie:**
  - 0x0000FF → function 3, value 255, dividend 0, delta 255.
  - 0xC8C832 → function 1 (R/G tie), dividend +150, delta 150.
  - 0x3264C8 → function 3, dividend −50 (0x1CE), delta 150.
- **Gray and COMP_W:**
  - 0x808080 → function 1, delta 0, gray 1.
  - With COMP_W=10: 0xFF0000 → value 1020, delta 1020.
- **Back-pressure:** stream 6 pixels with `i_ready` low for cycles 3–8.
  - Exactly 2 beats are buffered; `o_ready` drops.
  - Outputs are stable while stalled.
  - All 6 beats emerge in order with no loss or duplication.
- **Reset mid-stream:** assert `i_rst` asynchronously with 2 beats in flight.
  - All outputs go to 0 immediately.
  - After release, new pixels appear at latency 2.
- **Stats (`HSV_DEC_STATS_EN`):**
  - 10 handshakes including 3 gray → pix_cnt 10, gray_cnt 3.
  - `i_clr_stats` coincident with a handshake → both counters 0.
  - Preload near wrap (force counter to 0xFFFFFFFF) plus 1 handshake → 0.

Source files
------------

// File: rtl/hsv_decoder_pipe.sv
// ============================================================================
// Module   : hsv_decoder_pipe
// Brief    : RGB565/RGB888 to HSV front-end decoder, 2-stage valid/ready pipe.
//            Optional output-handshake statistics under HSV_DEC_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hsv_decoder_pipe #(
    parameter int COMP_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [23:0]       i_data,
    input  logic              i_fmt,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [COMP_W-1:0] o_value,
    output logic [COMP_W:0]   o_dividend,
    output logic [COMP_W:0]   o_delta,
    output logic [1:0]        o_function,
    output logic              o_gray,
    output logic              o_valid,
    input  logic              i_ready
`ifdef HSV_DEC_STATS_EN
    ,
    input  logic              i_clr_stats,
    output logic [31:0]       o_pix_cnt,
    output logic [31:0]       o_gray_cnt
`endif
);

    localparam int c_PAD8 = COMP_W - 8;
    localparam int c_PAD6 = COMP_W - 6;
    localparam int c_PAD5 = COMP_W - 5;

    logic [COMP_W-1:0] w_r, w_g, w_b;
    logic              w_in_xfer, w_s2_adv;

    logic [COMP_W-1:0] r_s1_r, r_s1_g, r_s1_b;
    logic              r_s1_r_ge_g, r_s1_r_ge_b, r_s1_g_ge_b;
    logic              r_s1_full;

    logic [COMP_W-1:0] w_max, w_min;
    logic [COMP_W:0]   w_div, w_delta;
    logic [1:0]        w_func;
    logic [COMP_W:0]   w_re, w_ge, w_be;

    // Left-justify each channel, zero-padding the LSBs
    always_comb begin
        if (i_fmt) begin
            w_r = COMP_W'(i_data[23:16]) << c_PAD8;
            w_g = COMP_W'(i_data[15:8])  << c_PAD8;
            w_b = COMP_W'(i_data[7:0])   << c_PAD8;
        end else begin
            w_r = COMP_W'(i_data[15:11]) << c_PAD5;
            w_g = COMP_W'(i_data[10:5])  << c_PAD6;
            w_b = COMP_W'(i_data[4:0])   << c_PAD5;
        end
    end

    assign w_s2_adv  = !o_valid | i_ready;
    assign o_ready   = !r_s1_full | w_s2_adv;
    assign w_in_xfer = i_valid & o_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_r      <= '0;
            r_s1_g      <= '0;
            r_s1_b      <= '0;
            r_s1_r_ge_g <= 1'b0;
            r_s1_r_ge_b <= 1'b0;
            r_s1_g_ge_b <= 1'b0;
            r_s1_full   <= 1'b0;
        end else begin
            r_s1_full <= w_in_xfer | (r_s1_full & !w_s2_adv);
            if (w_in_xfer) begin
                r_s1_r      <= w_r;
                r_s1_g      <= w_g;
                r_s1_b      <= w_b;
                r_s1_r_ge_g <= (w_r >= w_g);
                r_s1_r_ge_b <= (w_r >= w_b);
                r_s1_g_ge_b <= (w_g >= w_b);
            end
        end
    end

    assign w_re = {1'b0, r_s1_r};
    assign w_ge = {1'b0, r_s1_g};
    assign w_be = {1'b0, r_s1_b};

    // Tie priority R over G over B falls out of the >= comparisons
    always_comb begin
        w_max  = r_s1_b;
        w_min  = r_s1_r_ge_g ? r_s1_g : r_s1_r;
        w_func = 2'd3;
        w_div  = w_re - w_ge;
        if (r_s1_r_ge_g && r_s1_r_ge_b) begin
            w_max  = r_s1_r;
            w_min  = r_s1_g_ge_b ? r_s1_b : r_s1_g;
            w_func = 2'd1;
            w_div  = w_ge - w_be;
        end else if (r_s1_g_ge_b) begin
            w_max  = r_s1_g;
            w_min  = r_s1_r_ge_b ? r_s1_b : r_s1_r;
            w_func = 2'd2;
            w_div  = w_be - w_re;
        end
    end

    assign w_delta = {1'b0, w_max} - {1'b0, w_min};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_value    <= '0;
            o_dividend <= '0;
            o_delta    <= '0;
            o_function <= 2'd0;
            o_gray     <= 1'b0;
        end else if (w_s2_adv) begin
            o_valid <= r_s1_full;
            if (r_s1_full) begin
                o_value    <= w_max;
                o_dividend <= w_div;
                o_delta    <= w_delta;
                o_function <= w_func;
                o_gray     <= (w_delta == '0);
            end
        end
    end

`ifdef HSV_DEC_STATS_EN
    logic        w_out_xfer;
    logic [31:0] r_pix_cnt, r_gray_cnt;

    assign w_out_xfer = o_valid & i_ready;

    // Clear takes priority over a coincident handshake
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pix_cnt  <= 32'd0;
            r_gray_cnt <= 32'd0;
        end else if (i_clr_stats) begin
            r_pix_cnt  <= 32'd0;
            r_gray_cnt <= 32'd0;
        end else if (w_out_xfer) begin
            r_pix_cnt <= r_pix_cnt + 32'd1;
            if (o_gray) begin
                r_gray_cnt <= r_gray_cnt + 32'd1;
            end
        end
    end

    assign o_pix_cnt  = r_pix_cnt;
    assign o_gray_cnt = r_gray_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hsv_decoder_pipe.sv
// ============================================================================
// Module   : tb_hsv_decoder_pipe
// Brief    : Self-checking bench for hsv_decoder_pipe (COMP_W 8 and 10).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hsv_decoder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] data = '0;
    logic        fmt = 1'b0, valid = 1'b0, rdy_in = 1'b0;
    logic        clr = 1'b0;

    logic        o_ready, o_valid, o_gray;
    logic [7:0]  o_value;
    logic [8:0]  o_dividend, o_delta;
    logic [1:0]  o_function;

    logic        o_ready10, o_valid10, o_gray10;
    logic [9:0]  o_value10;
    logic [10:0] o_dividend10, o_delta10;
    logic [1:0]  o_function10;

    logic [31:0] pix_cnt, gray_cnt, pix_cnt10, gray_cnt10;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hsv_decoder_pipe #(.COMP_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_fmt(fmt), .i_valid(valid),
        .o_ready(o_ready), .o_value(o_value), .o_dividend(o_dividend),
        .o_delta(o_delta), .o_function(o_function), .o_gray(o_gray),
        .o_valid(o_valid), .i_ready(rdy_in)
`ifdef HSV_DEC_STATS_EN
        , .i_clr_stats(clr), .o_pix_cnt(pix_cnt), .o_gray_cnt(gray_cnt)
`endif
    );

    hsv_decoder_pipe #(.COMP_W(10)) dut10 (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_fmt(fmt), .i_valid(valid),
        .o_ready(o_ready10), .o_value(o_value10), .o_dividend(o_dividend10),
        .o_delta(o_delta10), .o_function(o_function10), .o_gray(o_gray10),
        .o_valid(o_valid10), .i_ready(rdy_in)
`ifdef HSV_DEC_STATS_EN
        , .i_clr_stats(clr), .o_pix_cnt(pix_cnt10), .o_gray_cnt(gray_cnt10)
`endif
    );

    logic [28:0] got8;
    logic [34:0] got10;
    assign got8  = {o_value, o_function, o_dividend, o_delta, o_gray};
    assign got10 = {o_value10, o_function10, o_dividend10, o_delta10, o_gray10};

    typedef struct {
        int value;
        int func;
        int div;
        int delta;
        int gray;
    } exp_t;

    // Reference: expand channels with plain arithmetic, then apply the HSV rules
    function automatic exp_t model(input bit f, input logic [23:0] d, input int w);
        exp_t e;
        int r, g, b, mx, mn, dv;
        if (f) begin
            r = int'(d[23:16]) * (1 << (w - 8));
            g = int'(d[15:8])  * (1 << (w - 8));
            b = int'(d[7:0])   * (1 << (w - 8));
        end else begin
            r = int'(d[15:11]) * (1 << (w - 5));
            g = int'(d[10:5])  * (1 << (w - 6));
            b = int'(d[4:0])   * (1 << (w - 5));
        end
        mx = (r > g) ? r : g;
        mx = (mx > b) ? mx : b;
        mn = (r < g) ? r : g;
        mn = (mn < b) ? mn : b;
        if (r >= g && r >= b) begin
            e.func = 1; dv = g - b;
        end else if (g >= b) begin
            e.func = 2; dv = b - r;
        end else begin
            e.func = 3; dv = r - g;
        end
        e.value = mx;
        e.delta = mx - mn;
        e.div   = (dv + (1 << (w + 1))) % (1 << (w + 1));
        e.gray  = (mx == mn) ? 1 : 0;
        return e;
    endfunction

    function automatic logic [28:0] pack8(input exp_t e);
        return {e.value[7:0], e.func[1:0], e.div[8:0], e.delta[8:0], e.gray[0]};
    endfunction

    function automatic logic [34:0] pack10(input exp_t e);
        return {e.value[9:0], e.func[1:0], e.div[10:0], e.delta[10:0], e.gray[0]};
    endfunction

    task automatic test_reset;
        rst = 1'b1; valid = 1'b0; rdy_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (got8 !== 29'd0 || o_valid !== 1'b0 || got10 !== 35'd0 || o_valid10 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%b %h/%b, want 0", got8, o_valid, got10, o_valid10);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", o_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: ready %b valid %b want 1 0", o_ready, o_valid);
        end
    endtask

    task automatic test_primaries;
        logic [23:0] tdata[6];
        logic        tfmt[6];
        logic [28:0] texp[6];
        tdata = '{24'h00F800, 24'h0007E0, 24'h0000FF, 24'hC8C832, 24'h3264C8, 24'h808080};
        tfmt  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        texp  = '{{8'd248, 2'd1, 9'd0,   9'd248, 1'b0},
                  {8'd252, 2'd2, 9'd0,   9'd252, 1'b0},
                  {8'd255, 2'd3, 9'd0,   9'd255, 1'b0},
                  {8'd200, 2'd1, 9'd150, 9'd150, 1'b0},
                  {8'd200, 2'd3, 9'h1CE, 9'd150, 1'b0},
                  {8'd128, 2'd1, 9'd0,   9'd0,   1'b1}};
        rdy_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            valid = 1'b1; data = tdata[i]; fmt = tfmt[i];
            @(posedge clk); #1;
            valid = 1'b0;
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0) begin
                errors++; $display("FAIL latency_early[%0d]: o_valid %b want 0", i, o_valid);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b1 || got8 !== texp[i]) begin
                errors++;
                $display("FAIL primary[%0d]: valid %b got %h want %h", i, o_valid, got8, texp[i]);
            end
        end
    endtask

    task automatic test_random_stream;
        exp_t        q8[$], q10[$], e;
        logic [28:0] snap;
        bit          stalled = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (got8 !== snap) begin
                    errors++; $display("FAIL stall_hold: got %h want %h", got8, snap);
                end
            end
            if (o_valid && rdy_in) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++; $display("FAIL stream8_extra: got %h want none", got8);
                end else begin
                    e = q8.pop_front();
                    if (got8 !== pack8(e)) begin
                        errors++; $display("FAIL stream8: got %h want %h", got8, pack8(e));
                    end
                end
            end
            if (o_valid10 && rdy_in) begin
                checks++;
                if (q10.size() == 0) begin
                    errors++; $display("FAIL stream10_extra: got %h want none", got10);
                end else begin
                    e = q10.pop_front();
                    if (got10 !== pack10(e)) begin
                        errors++; $display("FAIL stream10: got %h want %h", got10, pack10(e));
                    end
                end
            end
            stalled = o_valid && !rdy_in;
            snap    = got8;
            if (valid && o_ready)   q8.push_back(model(fmt, data, 8));
            if (valid && o_ready10) q10.push_back(model(fmt, data, 10));
            @(posedge clk); #1;
            if (k < 290) begin
                valid  = ($urandom_range(0, 3) != 0);
                data   = 24'($urandom);
                fmt    = 1'($urandom_range(0, 1));
                rdy_in = ($urandom_range(0, 2) != 0);
            end else begin
                valid  = 1'b0;
                rdy_in = 1'b1;
            end
        end
        checks++;
        if (q8.size() != 0 || q10.size() != 0) begin
            errors++; $display("FAIL stream_drain: left %0d/%0d want 0/0", q8.size(), q10.size());
        end
    endtask

    task automatic test_back_pressure;
        logic [23:0] pix[6];
        exp_t        q[$], e;
        logic [28:0] snap = '0;
        int          sent = 0, emitted = 0;
        for (int i = 0; i < 6; i++) pix[i] = 24'($urandom);
        @(posedge clk);
        for (int k = 1; k <= 25; k++) begin
            #1;
            rdy_in = !(k >= 3 && k <= 8);
            valid  = (sent < 6);
            data   = pix[(sent < 6) ? sent : 0];
            fmt    = 1'b1;
            @(negedge clk);
            if (k == 3) snap = got8;
            if (k >= 3 && k <= 8) begin
                checks++;
                if (o_ready !== 1'b0 || (sent - emitted) != 2 || got8 !== snap || o_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_stall[%0d]: ready %b held %0d out %h, want 0 2 %h", k, o_ready,
                             sent - emitted, got8, snap);
                end
            end
            if (k == 9) begin
                checks++;
                if (o_ready !== 1'b1) begin
                    errors++; $display("FAIL bp_resume: ready %b want 1", o_ready);
                end
            end
            if (o_valid && rdy_in) begin
                checks++;
                e = (q.size() != 0) ? q.pop_front() : model(1'b0, 24'h0, 8);
                if (emitted >= 6 || got8 !== pack8(e)) begin
                    errors++; $display("FAIL bp_order[%0d]: got %h want %h", emitted, got8, pack8(e));
                end
                emitted++;
            end
            if (valid && o_ready) begin
                q.push_back(model(1'b1, data, 8));
                sent++;
            end
            @(posedge clk);
        end
        checks++;
        if (emitted != 6 || q.size() != 0) begin
            errors++; $display("FAIL bp_count: emitted %0d want 6", emitted);
        end
    endtask

    task automatic test_reset_midstream;
        exp_t e;
        rdy_in = 1'b1;
        @(posedge clk); #1;
        valid = 1'b1; fmt = 1'b1; data = 24'h123456;
        @(posedge clk); #1;
        data = 24'h654321;
        @(posedge clk); #1;
        valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (got8 !== 29'd0 || o_valid !== 1'b0 || got10 !== 35'd0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: out %h valid %b ready %b want 0 0 1", got8, o_valid, o_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        valid = 1'b1; fmt = 1'b0; data = 24'($urandom);
        e = model(fmt, data, 8);
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_early: valid %b want 0", o_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || got8 !== pack8(e)) begin
            errors++; $display("FAIL post_reset_beat: valid %b got %h want %h", o_valid, got8, pack8(e));
        end
        @(posedge clk);
    endtask

    task automatic test_comp_w10;
        rdy_in = 1'b1;
        @(posedge clk); #1;
        valid = 1'b1; fmt = 1'b1; data = 24'hFF0000;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_valid10 !== 1'b1 || o_value10 !== 10'd1020 || o_delta10 !== 11'd1020 ||
            o_function10 !== 2'd1 || o_dividend10 !== 11'd0) begin
            errors++;
            $display("FAIL w10_red: value %0d delta %0d func %0d want 1020 1020 1", o_value10, o_delta10,
                     o_function10);
        end
        @(posedge clk);
    endtask

`ifdef HSV_DEC_STATS_EN
    task automatic test_stats;
        rdy_in = 1'b1;
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            valid = 1'b1; fmt = 1'b1;
            data  = (i == 0 || i == 3 || i == 6) ? 24'h808080 : 24'h102030 + 24'(i);
            @(posedge clk); #1;
        end
        valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pix_cnt !== 32'd10 || gray_cnt !== 32'd3) begin
            errors++; $display("FAIL stats_count: pix %0d gray %0d want 10 3", pix_cnt, gray_cnt);
        end
        @(posedge clk); #1;
        valid = 1'b1; data = 24'h808080;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checks++;
        if (pix_cnt !== 32'd0 || gray_cnt !== 32'd0) begin
            errors++; $display("FAIL stats_clear: pix %0d gray %0d want 0 0", pix_cnt, gray_cnt);
        end
        @(negedge clk);
        force dut.r_pix_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_pix_cnt;
        @(posedge clk); #1;
        valid = 1'b1; data = 24'h00FF00;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pix_cnt !== 32'd0) begin
            errors++; $display("FAIL stats_wrap: pix %h want 0", pix_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_primaries();
        test_random_stream();
        test_back_pressure();
        test_reset_midstream();
        test_comp_w10();
`ifdef HSV_DEC_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
